// File: rtl/mrd_rdx2345_pkg.sv
// rtl/mrd_rdx2345_pkg.sv - shared constants, types and helpers for the radix-2/3/4/5 read controller
//
// Contents:
//   NLANE        lane count of the butterfly datapath (5)
//   W_BIDX       width of a bank index (3)
//   BIDX_UNUSED  bank index marker for lanes beyond the active radix (7)
//   state_e      controller FSM states
//   lane_*_t     lane vector typedefs (data/address at the default widths)
//   mod5_add     modulo-5 add of two operands already reduced mod 5
package mrd_rdx2345_pkg;

    localparam int NLANE      = 5;
    localparam int W_BIDX     = 3;
    localparam int W_DATA_DEF = 30;
    localparam int W_ADDR_DEF = 8;

    localparam logic [W_BIDX-1:0] BIDX_UNUSED = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef logic [0:NLANE-1][W_BIDX-1:0]     lane_bidx_t;
    typedef logic [0:NLANE-1][W_DATA_DEF-1:0] lane_data_t;
    typedef logic [0:NLANE-1][W_ADDR_DEF-1:0] lane_addr_t;

    // Both operands must be in 0..4, so a single conditional subtract suffices.
    function automatic logic [W_BIDX-1:0] mod5_add(input logic [W_BIDX-1:0] a,
                                                   input logic [W_BIDX-1:0] b);
        logic [W_BIDX:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 4'd5) begin
            s = s - 4'd5;
        end
        return s[W_BIDX-1:0];
    endfunction

endpackage

// File: rtl/mrd_rdx2345_if.sv
// rtl/mrd_rdx2345_if.sv - lane-ordered beat stream into the radix-2/3/4/5 datapath
//
// Signals:
//   valid       one beat per cycle, no backpressure
//   d_real/imag per-lane sample
//   bank_index  per-lane source bank (7 for unused lanes)
//   bank_addr   per-lane bank address (0 for unused lanes), carried for write-back
// Modports: src (producer), snk (consumer).
interface mrd_rdx2345_if
    import mrd_rdx2345_pkg::*;
#(
    parameter int wDataInOut = 30,
    parameter int wAddr      = 8
);
    logic                                 valid;
    logic [0:NLANE-1][wDataInOut-1:0]     d_real;
    logic [0:NLANE-1][wDataInOut-1:0]     d_imag;
    logic [0:NLANE-1][W_BIDX-1:0]         bank_index;
    logic [0:NLANE-1][wAddr-1:0]          bank_addr;

    modport src (output valid, output d_real, output d_imag, output bank_index, output bank_addr);
    modport snk (input  valid, input  d_real, input  d_imag, input  bank_index, input  bank_addr);
endinterface

// File: rtl/mrd_rdx_addr_gen.sv
// rtl/mrd_rdx_addr_gen.sv - butterfly counter and per-lane bank index/address generator
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load_i         latch radix/stride and restart the butterfly counter at k=0
//   step_i         advance to the next butterfly
//   radix_i        requested radix (values outside 2..5 act as 5)
//   stride_m1_i    stride minus one
//   lane_idx_o     per-lane bank index for the current butterfly (7 = unused lane)
//   lane_addr_o    per-lane bank address for the current butterfly (0 = unused lane)
//
// k is held as k_lo in [0, stride) and k_hi. Every product in the address formula
// is replaced by a running sum, so the per-cycle path is adders only; the lane
// offsets j*stride and the k_hi step radix*stride are formed by shift/add at load.
module mrd_rdx_addr_gen
    import mrd_rdx2345_pkg::*;
#(
    parameter int wAddr = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_i,
    input  logic                          step_i,
    input  logic [2:0]                    radix_i,
    input  logic [wAddr-1:0]              stride_m1_i,
    output lane_bidx_t                    lane_idx_o,
    output logic [0:NLANE-1][wAddr-1:0]   lane_addr_o
);

    localparam logic [wAddr-1:0] A_ONE = {{(wAddr-1){1'b0}}, 1'b1};

    logic [2:0]                    radix_eff;
    logic [wAddr-1:0]              stride_d;
    logic [0:NLANE-1][wAddr-1:0]   loff_d;
    logic [wAddr-1:0]              rstride_d;

    logic [2:0]                    radix_q;
    logic [wAddr-1:0]              stride_m1_q;
    logic [0:NLANE-1][wAddr-1:0]   loff_q;      // j*stride
    logic [wAddr-1:0]              rstride_q;   // radix*stride
    logic [wAddr-1:0]              k_lo_q;
    logic [wAddr-1:0]              hi_base_q;   // k_hi*radix*stride
    logic [wAddr-1:0]              base_q;      // hi_base + k_lo
    logic [W_BIDX-1:0]             hi_mod5_q;   // k_hi mod 5
    logic [W_BIDX-1:0]             idx_base_q;  // (k_hi + k_lo) mod 5

    always_comb begin
        radix_eff = ((radix_i >= 3'd2) && (radix_i <= 3'd5)) ? radix_i : 3'd5;
        stride_d  = stride_m1_i + A_ONE;
        loff_d[0] = '0;
        loff_d[1] = stride_d;
        loff_d[2] = stride_d << 1;
        loff_d[3] = (stride_d << 1) + stride_d;
        loff_d[4] = stride_d << 2;
        case (radix_eff)
            3'd2:    rstride_d = loff_d[2];
            3'd3:    rstride_d = loff_d[3];
            3'd4:    rstride_d = loff_d[4];
            default: rstride_d = loff_d[4] + stride_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            radix_q     <= '0;
            stride_m1_q <= '0;
            loff_q      <= '0;
            rstride_q   <= '0;
            k_lo_q      <= '0;
            hi_base_q   <= '0;
            base_q      <= '0;
            hi_mod5_q   <= '0;
            idx_base_q  <= '0;
        end else if (load_i) begin
            radix_q     <= radix_eff;
            stride_m1_q <= stride_m1_i;
            loff_q      <= loff_d;
            rstride_q   <= rstride_d;
            k_lo_q      <= '0;
            hi_base_q   <= '0;
            base_q      <= '0;
            hi_mod5_q   <= '0;
            idx_base_q  <= '0;
        end else if (step_i) begin
            if (k_lo_q == stride_m1_q) begin
                // k_lo wraps: k_hi advances, base restarts at the new k_hi row.
                k_lo_q     <= '0;
                hi_base_q  <= hi_base_q + rstride_q;
                base_q     <= hi_base_q + rstride_q;
                hi_mod5_q  <= mod5_add(hi_mod5_q, 3'd1);
                idx_base_q <= mod5_add(hi_mod5_q, 3'd1);
            end else begin
                k_lo_q     <= k_lo_q + A_ONE;
                base_q     <= base_q + A_ONE;
                idx_base_q <= mod5_add(idx_base_q, 3'd1);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NLANE; j++) begin
            if (W_BIDX'(j) < radix_q) begin
                lane_idx_o[j]  = mod5_add(idx_base_q, W_BIDX'(j));
                lane_addr_o[j] = base_q + loff_q[j];
            end else begin
                lane_idx_o[j]  = BIDX_UNUSED;
                lane_addr_o[j] = '0;
            end
        end
    end

endmodule

// File: rtl/mrd_rdx2345_rdctrl.sv
// rtl/mrd_rdx2345_rdctrl.sv - read-side controller for the radix-2/3/4/5 DFT datapath
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  stage launch pulse (accepted only when idle)
//   radix, nbfly_m1,
//   stride_m1              stage configuration, latched on an accepted start
//   busy, done             stage in progress / one-cycle completion pulse
//   rd_en, rd_addr         shared bank read strobe and per-bank address
//   rd_real, rd_imag       bank read data, one cycle after rd_en
//   to_rdx                 lane-ordered beat stream with bank index/address
//
// Build option MRD_RDCTRL_OUTREG_EN: adds one output register stage after the
// crossbar, delaying the stream and done by one cycle.
module mrd_rdx2345_rdctrl
    import mrd_rdx2345_pkg::*;
#(
    parameter int wDataInOut = 30,
    parameter int wAddr      = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [2:0]                         radix,
    input  logic [wAddr-1:0]                   nbfly_m1,
    input  logic [wAddr-1:0]                   stride_m1,
    output logic                               busy,
    output logic                               done,
    output logic                               rd_en,
    output logic [0:NLANE-1][wAddr-1:0]        rd_addr,
    input  logic [0:NLANE-1][wDataInOut-1:0]   rd_real,
    input  logic [0:NLANE-1][wDataInOut-1:0]   rd_imag,
    mrd_rdx2345_if.src                         to_rdx
);

    localparam logic [wAddr-1:0] A_ONE = {{(wAddr-1){1'b0}}, 1'b1};

    // Cycles spent in DRAIN before done; covers the RAM and output register stages.
`ifdef MRD_RDCTRL_OUTREG_EN
    localparam logic [1:0] DRAIN_LAST = 2'd2;
`else
    localparam logic [1:0] DRAIN_LAST = 2'd1;
`endif

    state_e              state_q;
    logic                busy_q;
    logic                done_q;
    logic                rd_en_q;
    logic [wAddr-1:0]    kcnt_q;
    logic [wAddr-1:0]    nbfly_q;
    logic [1:0]          drain_q;

    // done_q excludes the done cycle so the earliest restart is one cycle later.
    logic accept;
    assign accept = start && (state_q == IDLE) && !done_q;

    lane_bidx_t                    lane_idx;
    logic [0:NLANE-1][wAddr-1:0]   lane_addr;

    mrd_rdx_addr_gen #(.wAddr(wAddr)) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .step_i      (state_q == READ),
        .radix_i     (radix),
        .stride_m1_i (stride_m1),
        .lane_idx_o  (lane_idx),
        .lane_addr_o (lane_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            kcnt_q  <= '0;
            nbfly_q <= '0;
            drain_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        nbfly_q <= nbfly_m1;
                        kcnt_q  <= '0;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (kcnt_q == nbfly_q) begin
                        rd_en_q <= 1'b0;
                        drain_q <= '0;
                        state_q <= DRAIN;
                    end else begin
                        kcnt_q <= kcnt_q + A_ONE;
                    end
                end
                DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rd_en = rd_en_q;

    // Lane-to-bank mapping: active lanes hit distinct banks, unused lanes (index 7) none.
    always_comb begin
        rd_addr = '0;
        for (int b = 0; b < NLANE; b++) begin
            for (int j = 0; j < NLANE; j++) begin
                if (rd_en_q && (lane_idx[j] == W_BIDX'(b))) begin
                    rd_addr[b] = lane_addr[j];
                end
            end
        end
    end

    // Stage 1: index/address held for the cycle the RAM returns data.
    logic                          v1_q;
    lane_bidx_t                    idx1_q;
    logic [0:NLANE-1][wAddr-1:0]   adr1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            idx1_q <= '0;
            adr1_q <= '0;
        end else begin
            v1_q <= rd_en_q;
            if (rd_en_q) begin
                idx1_q <= lane_idx;
                adr1_q <= lane_addr;
            end
        end
    end

    // Crossbar: bank order back to lane order; unused lanes match no bank and read 0.
    logic [0:NLANE-1][wDataInOut-1:0] xr;
    logic [0:NLANE-1][wDataInOut-1:0] xi;

    always_comb begin
        xr = '0;
        xi = '0;
        for (int j = 0; j < NLANE; j++) begin
            for (int b = 0; b < NLANE; b++) begin
                if (idx1_q[j] == W_BIDX'(b)) begin
                    xr[j] = rd_real[b];
                    xi[j] = rd_imag[b];
                end
            end
        end
    end

    // Stage 2: crossbar register.
    logic                               v2_q;
    logic [0:NLANE-1][wDataInOut-1:0]   re2_q;
    logic [0:NLANE-1][wDataInOut-1:0]   im2_q;
    lane_bidx_t                         idx2_q;
    logic [0:NLANE-1][wAddr-1:0]        adr2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            re2_q  <= '0;
            im2_q  <= '0;
            idx2_q <= '0;
            adr2_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                re2_q  <= xr;
                im2_q  <= xi;
                idx2_q <= idx1_q;
                adr2_q <= adr1_q;
            end
        end
    end

`ifdef MRD_RDCTRL_OUTREG_EN
    logic                               v3_q;
    logic [0:NLANE-1][wDataInOut-1:0]   re3_q;
    logic [0:NLANE-1][wDataInOut-1:0]   im3_q;
    lane_bidx_t                         idx3_q;
    logic [0:NLANE-1][wAddr-1:0]        adr3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q   <= 1'b0;
            re3_q  <= '0;
            im3_q  <= '0;
            idx3_q <= '0;
            adr3_q <= '0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) begin
                re3_q  <= re2_q;
                im3_q  <= im2_q;
                idx3_q <= idx2_q;
                adr3_q <= adr2_q;
            end
        end
    end

    assign to_rdx.valid      = v3_q;
    assign to_rdx.d_real     = re3_q;
    assign to_rdx.d_imag     = im3_q;
    assign to_rdx.bank_index = idx3_q;
    assign to_rdx.bank_addr  = adr3_q;
`else
    assign to_rdx.valid      = v2_q;
    assign to_rdx.d_real     = re2_q;
    assign to_rdx.d_imag     = im2_q;
    assign to_rdx.bank_index = idx2_q;
    assign to_rdx.bank_addr  = adr2_q;
`endif

endmodule

// File: doc/mrd_rdx2345_rdctrl.md
# mrd_rdx2345_rdctrl

Read-side controller feeding the radix-2/3/4/5 DFT-plus-twiddle datapath. For each butterfly of a stage, it generates per-lane bank index and address for the five data banks and issues one 5-lane read. It realigns the returned words to lane order and drives the `mrd_rdx2345_if` stream. That stream carries `valid`, the 5-lane data, and the bank index/address, which travel with the data for the in-place write-back.

## Interface
- `wDataInOut`, 30: width of each real/imag sample.
- `wAddr`, 8: bank address width; each of the five banks holds 2^wAddr words.
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that launches a stage; honoured only in IDLE.
- `radix`, in, 3: 2..5; latched on accepted `start`.
- `nbfly_m1`, in, wAddr: butterflies per stage minus one; latched.
- `stride_m1`, in, wAddr: stride minus one; latched. (nbfly_m1+1) is a multiple of (stride_m1+1).
- `busy`, out, 1: high from accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse after the last output beat.
- `rd_en`, out, 1: bank read strobe; all five banks share it.
- `rd_addr`, out, [0:4][wAddr-1:0]: per-bank read address.
- `rd_real` / `rd_imag`, in, [0:4][wDataInOut-1:0]: bank read data, valid exactly one cycle after `rd_en`.
- `to_rdx`, `mrd_rdx2345_if`: drives `valid`, `d_real`/`d_imag` [0:4][wDataInOut-1:0], `bank_index` [0:4][2:0] and `bank_addr` [0:4][wAddr-1:0].

## Operation
- States:
  - IDLE: on `start`, latch the config and go to READ.
  - READ: issue one butterfly per cycle. After butterfly nbfly_m1, go to DRAIN.
  - DRAIN: wait for the pipeline to empty, pulse `done`, return to IDLE.
- Butterfly counter k is split into k_lo ∈ [0, stride) and k_hi. k_lo increments first and wraps to 0, then k_hi increments.
- For lane j < radix:
  - bank_index[j] = (k_hi + k_lo + j) mod 5.
  - bank_addr[j] = (k_hi·radix + j)·stride + k_lo, truncated to wAddr.
  - Both are computed incrementally; no divider and no multiplier on the cycle path.
- Lanes j ≥ radix:
  - bank_index[j] = 7 (unused marker) and bank_addr[j] = 0.
  - Their banks are not addressed: `rd_addr` for such a bank is 0.
- Bank mapping: `rd_addr[bank_index[j]] = bank_addr[j]`. The mapping is one-to-one because the five lane banks are distinct mod 5.
- Return path: lane data `d_real[j] = rd_real[bank_index[j]]`, using the bank_index delayed to align with the read data. Unused lanes output 0.
- `bank_index`/`bank_addr` on `to_rdx` are delayed copies aligned with the data beat.
- The stream has no backpressure. The downstream radix pipe accepts one beat per cycle unconditionally.
- `start` while busy is ignored. Config inputs are ignored outside an accepted `start`.
- Radix values outside 2..5 are treated as 5.

## Timing
- `start` sampled high in IDLE at cycle t:
  - `busy` is high from t+1.
  - `rd_en` is high for cycles t+1 .. t+nbfly_m1+1, contiguously.
- `to_rdx.valid` is high for cycles t+3 .. t+nbfly_m1+3. Latency is 2 from `rd_en`: 1 for RAM, 1 for the crossbar register.
- `done` pulses at cycle t+nbfly_m1+4. `busy` drops in the same cycle.
- A new `start` is accepted at t+nbfly_m1+5 at the earliest.
- nbfly_m1 = 0 gives exactly one beat.
- Reset (asynchronous, any state): state returns to IDLE and counters clear. In-flight beats are discarded.
- Output reset values: `busy`, `done`, `rd_en`, `to_rdx.valid` are 0; all addresses, indices and data are 0.

## Configuration
- `MRD_RDCTRL_OUTREG_EN` defined: an extra register stage follows the crossbar.
  - `valid`, data and index/address all shift one cycle later.
  - `done` moves to t+nbfly_m1+5.
- Undefined: the timing is as given in the Timing section.

## Structure
- Package `mrd_rdx2345_pkg`:
  - lane count constant NLANE = 5.
  - bank-index width, 3.
  - unused-lane marker, 7.
  - state enum {IDLE, READ, DRAIN}.
  - typedefs for lane vectors of data, index and address.
- Sub-module `mrd_rdx_addr_gen`: k_lo/k_hi counters and per-lane index/address generation.
- The top level holds the FSM, bank mapping, alignment delay and crossbar.

## Test plan
- Radix 5, nbfly_m1=4, stride_m1=0; bank b word a preloaded with a·8+b:
  - 5 beats.
  - Beat k lane j = value at bank (k+j) mod 5, addr 5k+j.
  - `done` at t+8.
- Radix 2, nbfly_m1=3, stride_m1=1:
  - Lanes 2–4 give 0 with index 7.
  - Beat k=3 (k_hi=1, k_lo=1) lanes 0/1 come from bank 2 addr 5 and bank 3 addr 7.
- Radix 3, stride_m1=2, nbfly_m1=5: addresses per beat {0,3,6},{1,4,7},{2,5,8},{9,12,15},{10,13,16},{11,14,17}.
- `start` pulsed again mid-READ: ignored; beat count and `done` are unchanged.
- `rst_n` asserted at beat 2 of 5: all outputs are 0 immediately. After release, a new `start` runs a full stage correctly.
- `MRD_RDCTRL_OUTREG_EN` build, repeat test 1: `valid` at t+4..t+8, `done` at t+9, data identical.
